simd_mac_accum_overlay: RTL and testbench

//  Parametrised successor to the fixed 27x27 overlay MAC: multiplier + SIMD adder + accumulator,

---
 rtl/simd_mac_accum_overlay.sv | 218 +++++++++++++++++++++
 tb/tb_simd_mac_accum_overlay.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/simd_mac_accum_overlay.sv
// simd_mac_accum_overlay
//   Multiply-accumulate for a conv/GEMM overlay. It runs between operand fetch and
//   writeback. Each group of beats is accumulated into one result. Two modes:
//     mode=0 : one OP_W x OP_W product per beat (one ACC_W wide sum).
//     mode=1 : LANES independent LANE_W x LANE_W products. Each lane has its own
//              2*LANE_W bit field, and no carry passes between lanes.
//   Pipeline: products are registered at t+1 and the accumulator at t+2. out_valid
//   pulses at t_last+2.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mode                0 = full product, 1 = SIMD lanes (latched on the first beat of a group)
//   in_valid            operand beat (no backpressure)
//   a, b                operands, OP_W bits (lane i = bits [LANE_W*(i+1)-1 : LANE_W*i])
//   a_sign, b_sign      operand is two's complement
//   c_in                carry added at the lane-0 LSB on the first beat of a group
//   acc_len             beats per group, sampled on the first beat (0 acts as 1)
//   flush               end the current group early
//   out_valid           one-cycle pulse: result and lane_carry are valid
//   result              accumulated sum, ACC_W bits
//   lane_carry          sticky per-lane carry-out over the group
//   busy                high while accumulating or while a result is still in the pipe

module simd_mac_lane #(
   parameter int LANE_W = 9
) (
   input  logic [LANE_W-1:0]   a,
   input  logic [LANE_W-1:0]   b,
   input  logic                a_sign,
   input  logic                b_sign,
   output logic [2*LANE_W-1:0] prod
);
   logic signed [LANE_W:0]     ax, bx;
   logic signed [2*LANE_W-1:0] p;

   // The extra top bit makes one signed multiply serve both signed and unsigned.
   // Truncating to 2*LANE_W bits gives the correctly extended lane product.
   assign ax   = {a_sign & a[LANE_W-1], a};
   assign bx   = {b_sign & b[LANE_W-1], b};
   assign p    = ax * bx;
   assign prod = p;
endmodule

module simd_mac_accum_overlay #(
   parameter  int LANE_W = 9,
   parameter  int LANES  = 3,
   parameter  int CNT_W  = 8,
   localparam int OP_W   = LANE_W * LANES,
   localparam int ACC_W  = 2 * OP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic             a_sign,
   input  logic             b_sign,
   input  logic             c_in,
   input  logic [CNT_W-1:0] acc_len,
   input  logic             flush,
   output logic             out_valid,
   output logic [ACC_W-1:0] result,
   output logic [LANES-1:0] lane_carry,
   output logic             busy
);
   localparam int LW2 = 2 * LANE_W;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, len, count_inc;
   logic             grp_mode;
   logic             beat_first, beat_last, flush_end, beat_mode;

   // ---------------- group sequencing ----------------
   assign count_inc = count + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      beat_first = 1'b0;
      beat_last  = 1'b0;
      flush_end  = 1'b0;
      beat_mode  = grp_mode;
      case (state)
         IDLE: begin
            if (in_valid) begin
               beat_first = 1'b1;
               beat_mode  = mode;
               if (acc_len <= CNT_W'(1) || flush) beat_last = 1'b1;
               else                               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               if (count_inc == len || flush) begin
                  beat_last = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (flush) begin
               // This ends the group with no beat. The end tag still travels the pipe.
               flush_end = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         len      <= '0;
         grp_mode <= 1'b0;
      end else begin
         if (beat_first) begin
            grp_mode <= mode;
            len      <= (acc_len == '0) ? CNT_W'(1) : acc_len;
            count    <= CNT_W'(1);
         end else if (state == ACCUM && in_valid) begin
            count <= count_inc;
         end
         if (beat_last || flush_end) count <= '0;
      end
   end

   // ---------------- stage 1: products ----------------
   logic [LANES-1:0][LW2-1:0] lane_prod;
   logic signed [OP_W:0]      af, bf;
   logic signed [ACC_W-1:0]   full_prod;

   assign af        = {a_sign & a[OP_W-1], a};
   assign bf        = {b_sign & b[OP_W-1], b};
   assign full_prod = af * bf;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      simd_mac_lane #(.LANE_W(LANE_W)) u_lane (
         .a      (a[LANE_W*i +: LANE_W]),
         .b      (b[LANE_W*i +: LANE_W]),
         .a_sign (a_sign),
         .b_sign (b_sign),
         .prod   (lane_prod[i])
      );
   end

   logic             s1_vld, s1_first, s1_cin, s1_mode;
   logic [ACC_W-1:0] s1_prod;
   logic [2:1]       end_pipe;   // [1] = group end tag at stage 1, [2] = out_valid

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld   <= 1'b0;
         s1_first <= 1'b0;
         s1_cin   <= 1'b0;
         s1_mode  <= 1'b0;
         s1_prod  <= '0;
         end_pipe <= '0;
      end else begin
         s1_vld   <= in_valid;
         s1_first <= beat_first;
         s1_cin   <= beat_first & c_in;
         s1_mode  <= beat_mode;
         end_pipe <= {end_pipe[1], beat_last | flush_end};
         if (in_valid) s1_prod <= beat_mode ? lane_prod : full_prod;
      end
   end

   // ---------------- stage 2: SIMD accumulate ----------------
   logic [LANES-1:0][LW2-1:0] acc, base, addend, sum;
   logic [LANES-1:0]          acc_cy, co, lc_new;
   logic                      cy;

   // Lane adds are chained. In SIMD mode the chain is cut at every lane boundary.
   // In full mode it forms one ACC_W-bit add, and the top lane's carry-out is the
   // carry-out of the full add.
   always_comb begin
      base   = s1_first ? '0 : acc;
      addend = s1_vld ? s1_prod : '0;
      cy     = s1_cin;
      co     = '0;
      sum    = '0;
      for (int i = 0; i < LANES; i++) begin
         {co[i], sum[i]} = {1'b0, base[i]} + {1'b0, addend[i]} + {{LW2{1'b0}}, cy};
         cy = s1_mode ? 1'b0 : co[i];
      end
      if (s1_mode) begin
         lc_new = co | (s1_first ? '0 : acc_cy);
      end else begin
         lc_new            = '0;
         lc_new[LANES-1]   = co[LANES-1] | (~s1_first & acc_cy[LANES-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         acc_cy     <= '0;
         result     <= '0;
         lane_carry <= '0;
      end else begin
         if (s1_vld) begin
            acc    <= sum;
            acc_cy <= lc_new;
         end
         if (end_pipe[1]) begin
            result     <= sum;
            lane_carry <= lc_new;
         end
      end
   end

   assign out_valid = end_pipe[2];
   assign busy      = (state == ACCUM) | s1_vld | end_pipe[1];
endmodule

// File: tb/tb_simd_mac_accum_overlay.sv
// tb_simd_mac_accum_overlay
//   Directed cases and randomized groups for simd_mac_accum_overlay. Expected
//   results come from a per-group arithmetic model. A negedge monitor pairs them
//   with out_valid pulses in order.
module tb_simd_mac_accum_overlay;
   localparam int LANE_W = 9, LANES = 3, CNT_W = 8;
   localparam int OP_W = LANE_W * LANES, ACC_W = 2 * OP_W;

   logic             clk = 1'b0;
   logic             reset, mode, in_valid, a_sign, b_sign, c_in, flush;
   logic [OP_W-1:0]  a, b;
   logic [CNT_W-1:0] acc_len;
   logic             out_valid, busy;
   logic [ACC_W-1:0] result;
   logic [LANES-1:0] lane_carry;

   simd_mac_accum_overlay #(.LANE_W(LANE_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .a(a), .b(b),
      .a_sign(a_sign), .b_sign(b_sign), .c_in(c_in), .acc_len(acc_len), .flush(flush),
      .out_valid(out_valid), .result(result), .lane_carry(lane_carry), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [ACC_W-1:0] res;
      logic [LANES-1:0] lc;
      int               cyc;
   } exp_t;

   exp_t expq[$];
   int   n_out = 0, n_push = 0;

   task automatic push(input logic [ACC_W-1:0] r, input logic [LANES-1:0] l, input int c);
      exp_t e;
      e.res = r; e.lc = l; e.cyc = c + 2;
      expq.push_back(e);
      n_push++;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && out_valid) begin
         n_out++;
         if (expq.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
         end else begin
            e = expq.pop_front();
            chk("result",     64'(result),     64'(e.res));
            chk("lane_carry", 64'(lane_carry), 64'(e.lc));
            chk("latency",    64'(cyc),        64'(e.cyc));
         end
      end
   end

   // Drive one cycle of inputs. It is called just after a posedge and returns just after the next one.
   task automatic drv(input bit iv, input bit md, input logic [OP_W-1:0] aa, input logic [OP_W-1:0] bb,
                      input bit as_, input bit bs, input bit ci, input logic [CNT_W-1:0] ln, input bit fl);
      in_valid = iv; mode = md; a = aa; b = bb; a_sign = as_; b_sign = bs;
      c_in = ci; acc_len = ln; flush = fl;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input bit rnd_flush);
      for (int i = 0; i < n; i++)
         drv(1'b0, 1'($urandom), OP_W'($urandom), OP_W'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), CNT_W'($urandom), rnd_flush ? 1'($urandom) : 1'b0);
   endtask

   // ---------------- reference model ----------------
   logic [OP_W-1:0] ga[8], gb[8];

   function automatic longint sx(input longint v, input int w, input bit s);
      return (s && v[w-1]) ? v - (longint'(1) << w) : v;
   endfunction

   // Plain integer arithmetic over a whole group. A full-mode product is reduced
   // mod 2^ACC_W. A lane product is reduced mod 2^(2*LANE_W). Any add that reaches
   // 2^width sets that field's sticky carry.
   function automatic void model(input bit md, input bit as_, input bit bs, input bit ci, input int n,
                                 output logic [ACC_W-1:0] res, output logic [LANES-1:0] lc);
      longint acc, p, s, m;
      bit     cyo;
      res = '0; lc = '0;
      if (!md) begin
         m = (longint'(1) << ACC_W) - 1;
         acc = 0; cyo = 0;
         for (int k = 0; k < n; k++) begin
            p = (sx(longint'(ga[k]), OP_W, as_) * sx(longint'(gb[k]), OP_W, bs)) & m;
            s = ((k == 0) ? longint'(ci) : acc) + p;
            if ((s >> ACC_W) != 0) cyo = 1;
            acc = s & m;
         end
         res = ACC_W'(acc);
         lc[LANES-1] = cyo;
      end else begin
         m = (longint'(1) << (2*LANE_W)) - 1;
         for (int l = 0; l < LANES; l++) begin
            acc = 0; cyo = 0;
            for (int k = 0; k < n; k++) begin
               p = (sx(longint'(ga[k][LANE_W*l +: LANE_W]), LANE_W, as_) *
                    sx(longint'(gb[k][LANE_W*l +: LANE_W]), LANE_W, bs)) & m;
               s = ((k == 0) ? ((l == 0) ? longint'(ci) : 0) : acc) + p;
               if ((s >> (2*LANE_W)) != 0) cyo = 1;
               acc = s & m;
            end
            res[2*LANE_W*l +: 2*LANE_W] = (2*LANE_W)'(acc);
            lc[l] = cyo;
         end
      end
   endfunction

   initial begin
      bit               md, as_, bs, ci, fl;
      logic [CNT_W-1:0] lenf;
      int               eff, et, nb, lastc;
      logic [ACC_W-1:0] r;
      logic [LANES-1:0] l;

      reset = 1'b1; in_valid = 0; mode = 0; a = '0; b = '0; a_sign = 0; b_sign = 0;
      c_in = 0; acc_len = '0; flush = 0;
      @(posedge clk); #1;
      idle(3, 1'b0);
      chk("reset_out_valid",  64'(out_valid),  64'd0);
      chk("reset_result",     64'(result),     64'd0);
      chk("reset_lane_carry", 64'(lane_carry), 64'd0);
      chk("reset_busy",       64'(busy),       64'd0);
      reset = 1'b0;
      idle(2, 1'b1);

      // 1: single beat, 3*5
      lastc = cyc; drv(1, 0, 27'd3, 27'd5, 0, 0, 0, 8'd1, 0); push(54'd15, 3'b000, lastc);
      idle(3, 1'b0);

      // 2: four beats of 100*100 with one idle gap
      drv(1, 0, 27'd100, 27'd100, 0, 0, 0, 8'd4, 0);
      drv(1, 0, 27'd100, 27'd100, 0, 0, 0, 8'd4, 0);
      idle(1, 1'b0);
      chk("busy_accum", 64'(busy), 64'd1);
      drv(1, 0, 27'd100, 27'd100, 0, 0, 0, 8'd4, 0);
      lastc = cyc; drv(1, 0, 27'd100, 27'd100, 0, 0, 0, 8'd4, 0); push(54'd40000, 3'b000, lastc);
      idle(3, 1'b0);

      // 3: SIMD, two beats
      drv(1, 1, {9'd4, 9'd3, 9'd2}, {9'd7, 9'd6, 9'd5}, 0, 0, 0, 8'd2, 0);
      lastc = cyc; drv(1, 1, {9'd4, 9'd3, 9'd2}, {9'd7, 9'd6, 9'd5}, 0, 0, 0, 8'd2, 0);
      push({18'd56, 18'd36, 18'd20}, 3'b000, lastc);
      idle(3, 1'b0);

      // 4: SIMD signed -1*1 twice, lane 0 wraps
      drv(1, 1, 27'h1FF, 27'd1, 1, 1, 0, 8'd2, 0);
      lastc = cyc; drv(1, 1, 27'h1FF, 27'd1, 1, 1, 0, 8'd2, 0);
      push({36'd0, 18'h3FFFE}, 3'b001, lastc);
      idle(3, 1'b0);

      // 5: early flush on beat 2, then a back-to-back single-beat group
      drv(1, 0, 27'd10, 27'd10, 0, 0, 0, 8'd8, 0);
      lastc = cyc; drv(1, 0, 27'd10, 27'd10, 0, 0, 0, 8'd8, 1); push(54'd200, 3'b000, lastc);
      lastc = cyc; drv(1, 0, 27'd1, 27'd1, 0, 0, 0, 8'd1, 0);   push(54'd1, 3'b000, lastc);
      idle(4, 1'b0);

      // 6: reset mid-group, then a clean single beat
      for (int k = 0; k < 3; k++) drv(1, 0, 27'd7, 27'd9, 0, 0, 1, 8'd8, 0);
      reset = 1'b1;
      idle(3, 1'b0);
      chk("rst6_out_valid",  64'(out_valid),  64'd0);
      chk("rst6_result",     64'(result),     64'd0);
      chk("rst6_lane_carry", 64'(lane_carry), 64'd0);
      chk("rst6_busy",       64'(busy),       64'd0);
      reset = 1'b0;
      idle(4, 1'b0);
      lastc = cyc; drv(1, 0, 27'd2, 27'd3, 0, 0, 0, 8'd1, 0); push(54'd6, 3'b000, lastc);
      idle(3, 1'b0);

      // randomized groups: gaps, early flush with/without a beat, mid-group noise on mode/acc_len/c_in
      for (int g = 0; g < 250; g++) begin
         idle($urandom_range(0, 2), 1'b1);
         md = 1'($urandom); as_ = 1'($urandom); bs = 1'($urandom); ci = 1'($urandom);
         lenf = CNT_W'($urandom_range(0, 6));
         eff  = (lenf == 0) ? 1 : int'(lenf);
         et   = $urandom_range(0, 2);
         if (eff == 1 && et == 2) et = 0;
         nb = eff;
         if (et == 1) nb = $urandom_range(1, eff);
         if (et == 2) nb = $urandom_range(1, eff - 1);
         for (int k = 0; k < nb; k++) begin
            ga[k] = OP_W'($urandom);
            gb[k] = OP_W'($urandom);
            if ($urandom_range(0, 3) == 0) ga[k] = '1;
         end
         for (int k = 0; k < nb; k++) begin
            if (k > 0) idle($urandom_range(0, 2), 1'b0);
            fl = 1'b0;
            if (k == nb - 1 && et == 1) fl = 1'b1;
            if (k == nb - 1 && et == 0) fl = 1'($urandom);
            lastc = cyc;
            drv(1, (k == 0) ? md : 1'($urandom), ga[k], gb[k], as_, bs,
                (k == 0) ? ci : 1'($urandom), (k == 0) ? lenf : CNT_W'($urandom), fl);
         end
         if (et == 2) begin
            idle($urandom_range(0, 2), 1'b0);
            lastc = cyc;
            drv(0, 1'($urandom), OP_W'($urandom), OP_W'($urandom), as_, bs, 1'($urandom),
                CNT_W'($urandom), 1'b1);
         end
         model(md, as_, bs, ci, nb, r, l);
         push(r, l, lastc);
      end

      idle(6, 1'b0);
      chk("queue_drained", 64'(expq.size()), 64'd0);
      chk("out_count",     64'(n_out),       64'(n_push));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
